bidirectional_spi_responder: RTL and testbench

BIDIRECTIONAL_SPI_RESPONDER -- requirements
Module: bidirectional_spi_responder

---
 rtl/bidirectional_spi_responder.sv | 266 ++++++++++++++++++++++++++
 tb/tb_bidirectional_spi_responder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bidirectional_spi_responder.sv
// SPI responder with half-duplex sdio, bridging 1+ADDR+DATA frames to a register bus.
// Optional saturating abort counter built only with macro SPI_RESPONDER_ERR_CNT_EN.
//
// Ports:
//   fabric_clk, reset            : sole clock, synchronous active-high reset
//   spi_cpol, spi_cpha           : SPI mode, latched at frame start
//   spi_sclk, spi_cs_n, spi_sdio : async SPI pins, sdio driven only in read data phase
//   reg_addr, reg_wr_data        : register bus address / write data (hold between frames)
//   reg_wr_en, reg_rd_en         : single-cycle strobes
//   reg_rd_data                  : read data, valid one cycle after reg_rd_en
//   busy, frame_abort, err_count : status
module bidirectional_spi_responder #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  fabric_clk,
  input  logic                  reset,
  input  logic                  spi_cpol,
  input  logic                  spi_cpha,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  inout  wire                   spi_sdio,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic                  reg_wr_en,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  output logic                  busy,
  output logic                  frame_abort,
  output logic [7:0]            err_count
);

  localparam int CW = $clog2(ADDR_WIDTH + DATA_WIDTH + 2);
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] DATA_ALL  = CW'(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WR_DATA,
    S_RD_FETCH,
    S_RD_DATA,
    S_DONE
  } state_e;

  logic cs_s1_q, cs_s2_q, cs_prev_q;
  logic sclk_s1_q, sclk_s2_q, sclk_prev_q;
  logic sdio_s1_q, sdio_s2_q;
  logic [1:0] flush_q;
  logic armed_q;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic cpol_q, cpol_d;
  logic cpha_q, cpha_d;
  logic [ADDR_WIDTH-1:0] hdr_q, hdr_d;
  logic [DATA_WIDTH-2:0] wr_sh_q, wr_sh_d;
  logic [DATA_WIDTH-1:0] out_sh_q, out_sh_d;
  logic drv_q, drv_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic wr_en_q, wr_en_d;
  logic rd_en_q, rd_en_d;
  logic abort_q, abort_d;

  logic sclk_rise, sclk_fall, lead, trail, smp, lch;
  logic cs_fall, cs_rise;
  logic sdio_oe;
  logic do_abort;
  logic [ADDR_WIDTH:0] hdr_full;
  logic [DATA_WIDTH-1:0] wr_full;

  assign sclk_rise = sclk_s2_q & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s2_q & sclk_prev_q;
  assign lead  = cpol_q ? sclk_fall : sclk_rise;
  assign trail = cpol_q ? sclk_rise : sclk_fall;
  assign smp   = cpha_q ? trail : lead;
  assign lch   = cpha_q ? lead : trail;

  // A frame may only start once cs_n has been seen high after reset,
  // so a select held low through reset is not taken as a new frame.
  assign cs_fall = armed_q & cs_prev_q & ~cs_s2_q;
  assign cs_rise = ~cs_prev_q & cs_s2_q;

  assign hdr_full = {hdr_q, sdio_s2_q};
  assign wr_full  = {wr_sh_q, sdio_s2_q};

  assign sdio_oe  = drv_q & (state_q == S_RD_DATA) & ~cs_rise;
  assign spi_sdio = sdio_oe ? out_sh_q[DATA_WIDTH-1] : 1'bz;

  assign busy        = (state_q != S_IDLE);
  assign reg_addr    = addr_q;
  assign reg_wr_data = wdata_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_rd_en   = rd_en_q;
  assign frame_abort = abort_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    hdr_d    = hdr_q;
    wr_sh_d  = wr_sh_q;
    out_sh_d = out_sh_q;
    drv_d    = drv_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_en_d  = 1'b0;
    rd_en_d  = 1'b0;
    abort_d  = 1'b0;
    do_abort = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cs_fall) begin
          state_d = S_ADDR;
          cpol_d  = spi_cpol;
          cpha_d  = spi_cpha;
          cnt_d   = '0;
          drv_d   = 1'b0;
        end
      end
      S_ADDR: begin
        if (cs_rise) begin
          do_abort = 1'b1;
        end else if (smp) begin
          hdr_d = hdr_full[ADDR_WIDTH-1:0];
          if (cnt_q == ADDR_LAST) begin
            cnt_d  = '0;
            addr_d = hdr_full[ADDR_WIDTH-1:0];
            if (hdr_full[ADDR_WIDTH]) begin
              state_d = S_RD_FETCH;
              rd_en_d = 1'b1;
            end else begin
              state_d = S_WR_DATA;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_WR_DATA: begin
        // Final sample wins over a coincident cs_n rise.
        if (smp && cnt_q == DATA_LAST) begin
          wr_en_d = 1'b1;
          wdata_d = wr_full;
          state_d = cs_rise ? S_IDLE : S_DONE;
        end else if (cs_rise) begin
          do_abort = 1'b1;
        end else if (smp) begin
          wr_sh_d = wr_full[DATA_WIDTH-2:0];
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_RD_FETCH: begin
        // First cycle carries the rd_en pulse; data is captured on the second.
        if (cs_rise) begin
          do_abort = 1'b1;
        end else if (!rd_en_q) begin
          out_sh_d = reg_rd_data;
          cnt_d    = '0;
          state_d  = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (cs_rise) begin
          if (cnt_q == DATA_ALL) begin
            drv_d   = 1'b0;
            state_d = S_IDLE;
          end else begin
            do_abort = 1'b1;
          end
        end else if (lch) begin
          if (cnt_q == '0) begin
            drv_d = 1'b1;
            cnt_d = CW'(1);
          end else if (cnt_q < DATA_ALL) begin
            out_sh_d = {out_sh_q[DATA_WIDTH-2:0], 1'b0};
            cnt_d    = cnt_q + CW'(1);
          end else begin
            drv_d   = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (cs_rise) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (do_abort) begin
      state_d = S_IDLE;
      abort_d = 1'b1;
      drv_d   = 1'b0;
    end
  end

  always_ff @(posedge fabric_clk) begin
    if (reset) begin
      cs_s1_q     <= 1'b1;
      cs_s2_q     <= 1'b1;
      cs_prev_q   <= 1'b1;
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      sdio_s1_q   <= 1'b0;
      sdio_s2_q   <= 1'b0;
      flush_q     <= '0;
      armed_q     <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      hdr_q       <= '0;
      wr_sh_q     <= '0;
      out_sh_q    <= '0;
      drv_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      cs_s1_q     <= spi_cs_n;
      cs_s2_q     <= cs_s1_q;
      cs_prev_q   <= cs_s2_q;
      sclk_s1_q   <= spi_sclk;
      sclk_s2_q   <= sclk_s1_q;
      sclk_prev_q <= sclk_s2_q;
      sdio_s1_q   <= spi_sdio;
      sdio_s2_q   <= sdio_s1_q;
      // flush_q[1] marks that cs_s2_q now reflects the pin, not reset values.
      flush_q     <= {flush_q[0], 1'b1};
      armed_q     <= armed_q | (flush_q[1] & cs_s2_q);
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      hdr_q       <= hdr_d;
      wr_sh_q     <= wr_sh_d;
      out_sh_q    <= out_sh_d;
      drv_q       <= drv_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      abort_q     <= abort_d;
    end
  end

`ifdef SPI_RESPONDER_ERR_CNT_EN
  logic [7:0] err_q;
  always_ff @(posedge fabric_clk) begin
    if (reset) begin
      err_q <= '0;
    end else if (abort_q && err_q != 8'hFF) begin
      err_q <= err_q + 8'd1;
    end
  end
  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_bidirectional_spi_responder.sv
// Bench for bidirectional_spi_responder: bit-banged SPI initiator,
// register-bus responder and write/read scoreboards.
module tb_bidirectional_spi_responder;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int HALF = 6;
`ifdef SPI_RESPONDER_ERR_CNT_EN
  localparam logic [7:0] ERR_EXP = 8'd1;
`else
  localparam logic [7:0] ERR_EXP = 8'd0;
`endif

  logic fabric_clk = 1'b0;
  logic reset = 1'b1;
  logic spi_cpol = 1'b0;
  logic spi_cpha = 1'b0;
  logic spi_sclk = 1'b0;
  logic spi_cs_n = 1'b1;
  logic tb_oe = 1'b0;
  logic tb_bit = 1'b0;
  wire spi_sdio;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wr_data;
  logic reg_wr_en, reg_rd_en;
  logic [DW-1:0] reg_rd_data = '0;
  logic busy, frame_abort;
  logic [7:0] err_count;

  int n_tests = 0;
  int n_fail = 0;
  int n_wr = 0, n_rd = 0, n_abort = 0, n_oe = 0, n_busy = 0;
  logic [DW-1:0] mem [0:127];
  logic [DW-1:0] model [0:127];
  logic [AW+DW-1:0] exp_wr[$];
  logic [AW+DW-1:0] obs_wr[$];
  logic [DW-1:0] exp_rd[$];

  assign spi_sdio = tb_oe ? tb_bit : 1'bz;

  bidirectional_spi_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .fabric_clk(fabric_clk), .reset(reset),
    .spi_cpol(spi_cpol), .spi_cpha(spi_cpha),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_sdio(spi_sdio),
    .reg_addr(reg_addr), .reg_wr_data(reg_wr_data),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
    .reg_rd_data(reg_rd_data), .busy(busy),
    .frame_abort(frame_abort), .err_count(err_count)
  );

  always #5 fabric_clk = ~fabric_clk;

  always @(posedge fabric_clk) begin
    if (reg_rd_en) reg_rd_data <= mem[reg_addr];
    if (reg_wr_en) mem[reg_addr] <= reg_wr_data;
  end

  always @(negedge fabric_clk) begin
    if (reg_wr_en) begin
      obs_wr.push_back({reg_addr, reg_wr_data});
      n_wr++;
    end
    if (reg_rd_en) n_rd++;
    if (frame_abort) n_abort++;
    if (dut.sdio_oe) n_oe++;
    if (busy) n_busy++;
  end

  task automatic half_wait();
    repeat (HALF) @(negedge fabric_clk);
  endtask

  task automatic spi_xfer(input bit cpol, input bit cpha, input bit rw,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input int ndata, input int extra, input bit cs_last,
                          input bit raise, output logic [DW-1:0] rdata);
    logic [AW+DW:0] frame;
    int total;
    frame = {rw, addr, wdata};
    total = 1 + AW + ndata;
    rdata = '0;
    @(negedge fabric_clk);
    spi_cpol = cpol;
    spi_cpha = cpha;
    spi_sclk = cpol;
    tb_oe = 1'b0;
    repeat (8) @(negedge fabric_clk);
    spi_cs_n = 1'b0;
    if (!cpha) begin
      tb_oe = 1'b1;
      tb_bit = frame[AW+DW];
    end
    half_wait();
    for (int i = 0; i < total; i++) begin
      bit mine;
      mine = (i <= AW) || !rw;
      if (!cpha) begin
        if (!mine) rdata = {rdata[DW-2:0], spi_sdio};
        spi_sclk = ~cpol;
        if (cs_last && i == total - 1) spi_cs_n = 1'b1;
        half_wait();
        spi_sclk = cpol;
        if (i + 1 < total && ((i + 1) <= AW || !rw)) begin
          tb_oe = 1'b1;
          tb_bit = frame[AW+DW-(i+1)];
        end else begin
          tb_oe = 1'b0;
        end
        half_wait();
      end else begin
        spi_sclk = ~cpol;
        if (mine) begin
          tb_oe = 1'b1;
          tb_bit = frame[AW+DW-i];
        end else begin
          tb_oe = 1'b0;
        end
        half_wait();
        if (!mine) rdata = {rdata[DW-2:0], spi_sdio};
        spi_sclk = cpol;
        if (cs_last && i == total - 1) spi_cs_n = 1'b1;
        half_wait();
      end
    end
    tb_oe = 1'b0;
    for (int e = 0; e < extra; e++) begin
      spi_sclk = ~spi_sclk;
      half_wait();
    end
    if (raise) begin
      spi_cs_n = 1'b1;
      repeat (10) @(negedge fabric_clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge fabric_clk);
    reset = 1'b0;
    @(negedge fabric_clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    n_tests++; if (reg_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en got %b want 0", reg_wr_en); end
    n_tests++; if (reg_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en got %b want 0", reg_rd_en); end
    n_tests++; if (frame_abort !== 1'b0) begin n_fail++; $display("FAIL rst_abort got %b want 0", frame_abort); end
    n_tests++; if (reg_addr !== '0) begin n_fail++; $display("FAIL rst_addr got %h want 0", reg_addr); end
    n_tests++; if (reg_wr_data !== '0) begin n_fail++; $display("FAIL rst_wdata got %h want 0", reg_wr_data); end
    n_tests++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL rst_err got %0d want 0", err_count); end
    n_tests++; if (dut.sdio_oe !== 1'b0) begin n_fail++; $display("FAIL rst_oe got %b want 0", dut.sdio_oe); end
  endtask

  task automatic do_write(input string nm, input bit cpol, input bit cpha,
                          input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int extra, input bit cs_last);
    int w0, a0, o0, b0;
    logic [DW-1:0] rd;
    logic [AW+DW-1:0] e, o;
    w0 = n_wr; a0 = n_abort; o0 = n_oe; b0 = n_busy;
    exp_wr.push_back({a, d});
    model[a] = d;
    spi_xfer(cpol, cpha, 1'b0, a, d, DW, extra, cs_last, 1'b1, rd);
    e = exp_wr.pop_front();
    n_tests++; if (n_wr - w0 != 1) begin n_fail++; $display("FAIL %s wr_pulses got %0d want 1", nm, n_wr - w0); end
    n_tests++;
    if (obs_wr.size() == 0) begin
      n_fail++; $display("FAIL %s wr_data got none want %h", nm, e);
    end else begin
      o = obs_wr.pop_front();
      if (o !== e) begin n_fail++; $display("FAIL %s wr_data got %h want %h", nm, o, e); end
    end
    obs_wr.delete();
    n_tests++; if (n_abort - a0 != 0) begin n_fail++; $display("FAIL %s abort got %0d want 0", nm, n_abort - a0); end
    n_tests++; if (n_oe - o0 != 0) begin n_fail++; $display("FAIL %s sdio_driven got %0d want 0", nm, n_oe - o0); end
    n_tests++; if (n_busy - b0 == 0) begin n_fail++; $display("FAIL %s busy_seen got 0 want >0", nm); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_after got %b want 0", nm, busy); end
  endtask

  task automatic do_read(input string nm, input bit cpol, input bit cpha,
                         input logic [AW-1:0] a);
    int r0, a0, w0;
    logic [DW-1:0] rd, e;
    r0 = n_rd; a0 = n_abort; w0 = n_wr;
    exp_rd.push_back(model[a]);
    spi_xfer(cpol, cpha, 1'b1, a, '0, DW, 0, 1'b0, 1'b1, rd);
    e = exp_rd.pop_front();
    n_tests++; if (rd !== e) begin n_fail++; $display("FAIL %s rd_data got %h want %h", nm, rd, e); end
    n_tests++; if (n_rd - r0 != 1) begin n_fail++; $display("FAIL %s rd_pulses got %0d want 1", nm, n_rd - r0); end
    n_tests++; if (n_wr - w0 != 0) begin n_fail++; $display("FAIL %s wr_pulses got %0d want 0", nm, n_wr - w0); end
    n_tests++; if (n_abort - a0 != 0) begin n_fail++; $display("FAIL %s abort got %0d want 0", nm, n_abort - a0); end
    n_tests++; if (dut.sdio_oe !== 1'b0) begin n_fail++; $display("FAIL %s oe_after got %b want 0", nm, dut.sdio_oe); end
  endtask

  task automatic test_write_mode0();
    do_write("wr_m0", 1'b0, 1'b0, 7'h15, 32'hDEADBEEF, 0, 1'b0);
  endtask

  task automatic test_read_mode3();
    mem[7'h7F] = 32'hA5A5F00F;
    model[7'h7F] = 32'hA5A5F00F;
    do_read("rd_m3", 1'b1, 1'b1, 7'h7F);
  endtask

  task automatic test_modes12();
    do_write("wr_m1", 1'b0, 1'b1, 7'h01, 32'h12345678, 0, 1'b0);
    do_read("rd_m2", 1'b1, 1'b0, 7'h01);
    do_write("wr_m2", 1'b1, 1'b0, 7'h02, 32'h0F1E2D3C, 0, 1'b0);
    do_read("rd_m1", 1'b0, 1'b1, 7'h02);
  endtask

  task automatic test_abort();
    int w0, a0;
    logic [DW-1:0] rd;
    w0 = n_wr; a0 = n_abort;
    spi_xfer(1'b0, 1'b0, 1'b0, 7'h22, 32'h0BADF00D, 20, 0, 1'b0, 1'b1, rd);
    n_tests++; if (n_wr - w0 != 0) begin n_fail++; $display("FAIL abort_wr got %0d want 0", n_wr - w0); end
    n_tests++; if (n_abort - a0 != 1) begin n_fail++; $display("FAIL abort_pulse got %0d want 1", n_abort - a0); end
    n_tests++; if (err_count !== ERR_EXP) begin n_fail++; $display("FAIL abort_err got %0d want %0d", err_count, ERR_EXP); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
    obs_wr.delete();
  endtask

  task automatic test_reset_mid_read();
    int a0;
    logic [DW-1:0] rd, e;
    e = model[7'h7F] >> (DW - 10);
    spi_xfer(1'b0, 1'b0, 1'b1, 7'h7F, '0, 10, 0, 1'b0, 1'b0, rd);
    n_tests++; if (rd !== e) begin n_fail++; $display("FAIL mid_rd_bits got %h want %h", rd, e); end
    n_tests++; if (dut.sdio_oe !== 1'b1) begin n_fail++; $display("FAIL mid_rd_oe got %b want 1", dut.sdio_oe); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_rd_busy got %b want 1", busy); end
    a0 = n_abort;
    @(negedge fabric_clk);
    reset = 1'b1;
    @(posedge fabric_clk);
    #1;
    n_tests++; if (dut.sdio_oe !== 1'b0) begin n_fail++; $display("FAIL rst_mid_oe got %b want 0", dut.sdio_oe); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    @(negedge fabric_clk);
    reset = 1'b0;
    repeat (3) @(negedge fabric_clk);
    spi_cs_n = 1'b1;
    repeat (10) @(negedge fabric_clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_rearm_busy got %b want 0", busy); end
    n_tests++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL rst_err got %0d want 0", err_count); end
    n_tests++; if (n_abort - a0 != 0) begin n_fail++; $display("FAIL rst_abort got %0d want 0", n_abort - a0); end
    do_write("wr_after_rst", 1'b0, 1'b0, 7'h33, 32'hCAFEF00D, 0, 1'b0);
  endtask

  task automatic test_cs_at_last_edge();
    do_write("wr_cs_last", 1'b0, 1'b0, 7'h44, 32'h55AA33CC, 0, 1'b1);
  endtask

  task automatic test_extra_edges();
    do_write("wr_extra", 1'b0, 1'b0, 7'h05, 32'h0F0F1234, 40, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_read("rd_b2b_a", 1'b0, 1'b0, 7'h44);
    do_read("rd_b2b_b", 1'b1, 1'b1, 7'h15);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem[i] = '0;
      model[i] = '0;
    end
    test_reset();
    test_write_mode0();
    test_read_mode3();
    test_modes12();
    test_abort();
    test_reset_mid_read();
    test_cs_at_last_edge();
    test_extra_edges();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
